// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and address helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Instructions are one 16-bit word, byte addressed.
    localparam lc3b_word INSTR_BYTES = 16'd2;

    // Sequential successor of an instruction address; wraps at 16 bits.
    function automatic lc3b_word next_word_addr(input lc3b_word addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Holds the next fetch address (pc) and the outstanding request address (req_addr).
// Latency: a load is visible one cycle after its enable is sampled.
// Backpressure: none; the loads are driven by the fetch controller.
module fetch_pc_reg
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     pc_load,
    input  lc3b_word pc_in,
    input  logic     req_load,
    input  lc3b_word req_in,
    output lc3b_word pc,
    output lc3b_word req_addr
);

    // Next fetch address: reset to the boot vector, otherwise load on demand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= pc_in;
        end
    end

    // Address driven to memory; only changes when no request is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_addr <= RESET_PC;
        end else if (req_load) begin
            req_addr <= req_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding port-A read, a single output slot, redirect flush.
// Latency: if_valid rises the cycle after mem_resp_a (zero-wait memory gives 1 cycle).
// Backpressure: stall holds the slot and suppresses new requests; redirect overrides stall.
module fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    input  logic     mem_resp_a,
    input  lc3b_word mem_rdata_a,
    output logic     mem_read_a,
    output lc3b_word mem_address_a,
    output logic     if_valid,
    output lc3b_word if_ir,
    output lc3b_word if_pc,
    output lc3b_word if_pc_next
);

    // S_DROP: a request is in flight whose data is stale after a redirect; the
    // read must still complete with a stable address before refetching.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    lc3b_word pc;
    lc3b_word req_addr;
    logic     pc_load;
    lc3b_word pc_in;
    logic     req_load;
    lc3b_word req_in;
    logic     slot_load;
    logic     slot_clear;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .pc_load  (pc_load),
        .pc_in    (pc_in),
        .req_load (req_load),
        .req_in   (req_in),
        .pc       (pc),
        .req_addr (req_addr)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, address-register loads and slot control.
    always_comb begin
        state_next = state;
        mem_read_a = 1'b0;
        pc_load    = 1'b0;
        pc_in      = pc;
        req_load   = 1'b0;
        req_in     = req_addr;
        slot_load  = 1'b0;
        slot_clear = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read_a = 1'b1;
                if (mem_resp_a && redirect) begin
                    // Returned word is on the wrong path; restart at the target.
                    pc_load  = 1'b1;
                    pc_in    = redirect_pc;
                    req_load = 1'b1;
                    req_in   = redirect_pc;
                end else if (mem_resp_a) begin
                    slot_load  = 1'b1;
                    pc_load    = 1'b1;
                    pc_in      = next_word_addr(req_addr);
                    state_next = S_FULL;
                end else if (redirect) begin
                    // Address must stay put until the pending read completes.
                    pc_load    = 1'b1;
                    pc_in      = redirect_pc;
                    state_next = S_DROP;
                end
            end

            S_FULL: begin
                if (redirect) begin
                    slot_clear = 1'b1;
                    pc_load    = 1'b1;
                    pc_in      = redirect_pc;
                    req_load   = 1'b1;
                    req_in     = redirect_pc;
                    state_next = S_FETCH;
                end else if (!stall) begin
                    slot_clear = 1'b1;
                    req_load   = 1'b1;
                    req_in     = pc;
                    state_next = S_FETCH;
                end
            end

            S_DROP: begin
                mem_read_a = 1'b1;
                if (mem_resp_a) begin
                    // Latest redirect wins, including one arriving with the response.
                    req_load   = 1'b1;
                    req_in     = redirect ? redirect_pc : pc;
                    pc_load    = redirect;
                    pc_in      = redirect_pc;
                    state_next = S_FETCH;
                end else if (redirect) begin
                    pc_load = 1'b1;
                    pc_in   = redirect_pc;
                end
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Output slot: captured on a good response, invalidated when consumed or flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_valid <= 1'b0;
            if_ir    <= '0;
            if_pc    <= '0;
        end else if (slot_load) begin
            if_valid <= 1'b1;
            if_ir    <= mem_rdata_a;
            if_pc    <= req_addr;
        end else if (slot_clear) begin
            if_valid <= 1'b0;
        end
    end

    assign mem_address_a = req_addr;
    assign if_pc_next    = next_word_addr(if_pc);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_resp_a;
    logic [15:0] mem_rdata_a;
    logic        mem_read_a;
    logic [15:0] mem_address_a;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_resp_a    (mem_resp_a),
        .mem_rdata_a   (mem_rdata_a),
        .mem_read_a    (mem_read_a),
        .mem_address_a (mem_address_a),
        .if_valid      (if_valid),
        .if_ir         (if_ir),
        .if_pc         (if_pc),
        .if_pc_next    (if_pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_resp_a  = 1'b0;
        mem_rdata_a = 16'h0000;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();

        // Reset state
        chk("rst_read", {15'd0, mem_read_a}, 16'h0001);
        chk("rst_addr", mem_address_a, 16'h0000);
        chk("rst_valid", {15'd0, if_valid}, 16'h0000);
        chk("rst_ir", if_ir, 16'h0000);
        chk("rst_pc", if_pc, 16'h0000);

        // First fetch with two wait cycles
        reset_n = 1'b1;
        step();
        chk("w1_addr", mem_address_a, 16'h0000);
        chk("w1_valid", {15'd0, if_valid}, 16'h0000);
        step();
        chk("w2_read", {15'd0, mem_read_a}, 16'h0001);
        mem_resp_a  = 1'b1;
        mem_rdata_a = 16'h1234;
        step();
        mem_resp_a = 1'b0;
        stall      = 1'b1;
        chk("f1_valid", {15'd0, if_valid}, 16'h0001);
        chk("f1_ir", if_ir, 16'h1234);
        chk("f1_pc", if_pc, 16'h0000);
        chk("f1_pc_next", if_pc_next, 16'h0002);
        chk("f1_read", {15'd0, mem_read_a}, 16'h0000);

        // Stall held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ir", if_ir, 16'h1234);
            chk("stall_valid", {15'd0, if_valid}, 16'h0001);
            chk("stall_read", {15'd0, mem_read_a}, 16'h0000);
        end
        stall = 1'b0;
        step();
        chk("cons_addr", mem_address_a, 16'h0002);
        chk("cons_read", {15'd0, mem_read_a}, 16'h0001);
        chk("cons_valid", {15'd0, if_valid}, 16'h0000);

        // Redirect while waiting: old request drains with stable address
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h4000;
        step();
        redirect = 1'b0;
        chk("drop_addr0", mem_address_a, 16'h0002);
        chk("drop_read0", {15'd0, mem_read_a}, 16'h0001);
        step();
        chk("drop_addr1", mem_address_a, 16'h0002);
        mem_resp_a  = 1'b1;
        mem_rdata_a = 16'hDEAD;
        step();
        mem_resp_a = 1'b0;
        chk("drop_valid", {15'd0, if_valid}, 16'h0000);
        chk("drop_next_addr", mem_address_a, 16'h4000);
        chk("drop_next_read", {15'd0, mem_read_a}, 16'h0001);
        step();
        chk("drop_no_data", {15'd0, if_valid}, 16'h0000);

        // Normal zero-wait fetch at 4000, then consume
        mem_resp_a  = 1'b1;
        mem_rdata_a = 16'h1111;
        step();
        mem_resp_a = 1'b0;
        chk("f2_ir", if_ir, 16'h1111);
        chk("f2_pc", if_pc, 16'h4000);
        chk("f2_pc_next", if_pc_next, 16'h4002);
        step();
        chk("f2_next_addr", mem_address_a, 16'h4002);

        // Redirect coincident with response
        mem_resp_a  = 1'b1;
        mem_rdata_a = 16'hBEEF;
        redirect    = 1'b1;
        redirect_pc = 16'h4000;
        step();
        mem_resp_a = 1'b0;
        redirect   = 1'b0;
        chk("coin_valid", {15'd0, if_valid}, 16'h0000);
        chk("coin_addr", mem_address_a, 16'h4000);
        chk("coin_read", {15'd0, mem_read_a}, 16'h0001);

        // Redirect and stall together in the full state
        mem_resp_a  = 1'b1;
        mem_rdata_a = 16'h2222;
        step();
        mem_resp_a = 1'b0;
        chk("f3_ir", if_ir, 16'h2222);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h1230;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("rs_valid", {15'd0, if_valid}, 16'h0000);
        chk("rs_addr", mem_address_a, 16'h1230);
        chk("rs_read", {15'd0, mem_read_a}, 16'h0001);

        // Wrap at FFFE
        mem_resp_a  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap_addr", mem_address_a, 16'hFFFE);
        mem_rdata_a = 16'h3333;
        step();
        mem_resp_a = 1'b0;
        chk("wrap_pc", if_pc, 16'hFFFE);
        chk("wrap_pc_next", if_pc_next, 16'h0000);
        step();
        chk("wrap_next_addr", mem_address_a, 16'h0000);

        // Successive redirects while draining; the last one wins
        redirect    = 1'b1;
        redirect_pc = 16'h5000;
        step();
        redirect_pc = 16'h6000;
        step();
        redirect = 1'b0;
        chk("multi_addr", mem_address_a, 16'h0000);
        step();
        mem_resp_a = 1'b1;
        step();
        mem_resp_a = 1'b0;
        chk("multi_last", mem_address_a, 16'h6000);
        chk("multi_valid", {15'd0, if_valid}, 16'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'h6100;
        step();
        redirect_pc = 16'h7000;
        mem_resp_a  = 1'b1;
        step();
        redirect   = 1'b0;
        mem_resp_a = 1'b0;
        chk("multi_coin", mem_address_a, 16'h7000);

        // Reset asserted mid-request abandons it
        step();
        reset_n = 1'b0;
        #1;
        chk("arst_addr", mem_address_a, 16'h0000);
        chk("arst_read", {15'd0, mem_read_a}, 16'h0001);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_addr", mem_address_a, 16'h0000);
        mem_resp_a  = 1'b1;
        mem_rdata_a = 16'h5555;
        step();
        mem_resp_a = 1'b0;
        chk("post_rst_ir", if_ir, 16'h5555);
        chk("post_rst_pc", if_pc, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first instruction address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  decode/control stage not accepting the held instruction this cycle.
REQ-005 SHALL have port redirect  input  1  taken branch/JMP/JSR/TRAP from a later stage; flush and refetch.
REQ-006 SHALL have port redirect_pc  input  16 (lc3b_word)  redirect target address.
REQ-007 SHALL have port mem_resp_a  input  1  port-A read complete.
REQ-008 SHALL have port mem_rdata_a  input  16  port-A read data.
REQ-009 SHALL have port mem_read_a  output  1  port-A read request, held until mem_resp_a.
REQ-010 SHALL have port mem_address_a  output  16  port-A address, equal to req_addr.
REQ-011 SHALL have port if_valid  output  1  if_ir/if_pc hold a valid instruction.
REQ-012 SHALL have port if_ir  output  16  fetched instruction word.
REQ-013 SHALL have port if_pc  output  16  address of if_ir.
REQ-014 SHALL have port if_pc_next  output  16  if_pc + 2, combinational.

Function
REQ-015 SHALL hold registers: state, pc (next fetch address), req_addr (address of the outstanding request), and the output slot (if_valid, if_ir, if_pc).
REQ-016 SHALL use states S_FETCH, S_FULL and S_DROP.
REQ-017 S_FETCH SHALL assert mem_read_a, with if_valid = 0 throughout.
REQ-018 S_FETCH with mem_resp_a and no redirect SHALL load if_ir <= mem_rdata_a, if_pc <= req_addr, if_valid <= 1, pc <= req_addr + 2 (16-bit wrap), and go to S_FULL.
REQ-019 S_FETCH with mem_resp_a and redirect in the same cycle SHALL discard the data, set pc and req_addr <= redirect_pc, and stay in S_FETCH.
REQ-020 S_FETCH with redirect and no mem_resp_a SHALL set pc <= redirect_pc, keep req_addr, and go to S_DROP.
REQ-021 S_FULL SHALL deassert mem_read_a.
REQ-022 S_FULL with redirect SHALL clear if_valid, set pc and req_addr <= redirect_pc, and go to S_FETCH; redirect has priority over stall.
REQ-023 S_FULL with stall low (instruction consumed) SHALL clear if_valid, set req_addr <= pc, and go to S_FETCH.
REQ-024 S_FULL with stall high SHALL hold all registers unchanged.
REQ-025 S_DROP SHALL hold mem_read_a high with mem_address_a stable until mem_resp_a, never presenting the returned data.
REQ-026 S_DROP with mem_resp_a SHALL set req_addr <= pc and go to S_FETCH.
REQ-027 A redirect in S_DROP SHALL overwrite pc (latest redirect wins), including when it coincides with mem_resp_a, in which case req_addr <= redirect_pc.
REQ-028 mem_address_a SHALL never change while mem_read_a is high and mem_resp_a has not yet been seen.
REQ-029 Minimum fetch latency SHALL be request issue to if_valid = 1 in the cycle after mem_resp_a.

Reset
REQ-030 On reset_n low, asynchronously: state = S_FETCH, pc = req_addr = RESET_PC, if_valid = 0, if_ir = 0, if_pc = 0.
REQ-031 Reset asserted mid-request SHALL abandon the request; the first request after release SHALL be at RESET_PC with mem_read_a = 1.

Structure
REQ-032 lc3b_word SHALL come from the shared lc3b_types package.
REQ-033 The fetch state enum SHALL be local to the module and SHALL NOT be placed in lc3b_types.
REQ-034 Sub-module fetch_pc_reg SHALL implement pc/req_addr with async-reset load.
REQ-035 No other sub-modules SHALL be used.

Verification
REQ-036 Reset release with mem_resp_a after 2 wait cycles and data 16'h1234: mem_address_a = 16'h0000; if_valid = 1, if_ir = 16'h1234, if_pc = 16'h0000, if_pc_next = 16'h0002.
REQ-037 stall held high 3 cycles in S_FULL: if_ir unchanged and mem_read_a = 0; on stall low, the next request goes to 16'h0002.
REQ-038 Redirect to 16'h4000 while waiting on a request to 16'h0002: mem_address_a stays 16'h0002 until mem_resp_a with data not presented, then a request goes to 16'h4000.
REQ-039 Redirect to 16'h4000 coincident with mem_resp_a: if_valid stays 0, and the next cycle requests 16'h4000.
REQ-040 Redirect and stall together in S_FULL: if_valid clears, and the next request goes to redirect_pc.
REQ-041 Fetch at 16'hFFFE: pc wraps to 16'h0000, and if_pc_next = 16'h0000.
